// File: rtl/mul_acc_pkg.sv
// mul_acc_pkg: shared widths, group-state encoding and saturating add for the
// multiply-accumulate stage.
//   PROD_W  width of one multiplier product
//   CNT_W   width of the in-group product counter (acc_last_cnt)
//   sat_add unsigned add clamped to 2^w-1; used only when MUL_ACC_SAT_EN is defined
package mul_acc_pkg;

    localparam int PROD_W = 16;
    localparam int CNT_W  = 8;

    typedef enum logic {
        ACC_STATE_IDLE  = 1'b0,
        ACC_STATE_ACCUM = 1'b1
    } acc_state_e;

    // Operands are held in 64 bits so one function serves every ACC_W (< 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] s;
        logic [63:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (64'd1 << w) - 64'd1;
        return (s > {1'b0, lim}) ? lim : s[63:0];
    endfunction

endpackage

// File: rtl/mul_acc_if.sv
// mul_acc_if: product input, clear, and result handshake bundle of mul_acc_stage.
//   prod_en_in/prod_in  product strobe and value from the multiplier
//   clr_in              synchronous clear of the partial group and ovf_flag
//   acc_valid/acc_ready/acc_out  result handshake and data
//   acc_last_cnt        products in the open group
//   ovf_flag            sticky dropped-result flag
//   modport master: producer/consumer side; modport slave: the stage itself
interface mul_acc_if #(
    parameter int ACC_W = 20
);
    import mul_acc_pkg::*;

    logic              prod_en_in;
    logic [PROD_W-1:0] prod_in;
    logic              clr_in;
    logic              acc_valid;
    logic              acc_ready;
    logic [ACC_W-1:0]  acc_out;
    logic [CNT_W-1:0]  acc_last_cnt;
    logic              ovf_flag;

    modport master (
        output prod_en_in, prod_in, clr_in, acc_ready,
        input  acc_valid, acc_out, acc_last_cnt, ovf_flag
    );

    modport slave (
        input  prod_en_in, prod_in, clr_in, acc_ready,
        output acc_valid, acc_out, acc_last_cnt, ovf_flag
    );

endinterface

// File: rtl/mul_acc_fifo.sv
// mul_acc_fifo: 2-entry result FIFO with registered head.
//   clk, rst_n  clock and asynchronous active-low reset
//   push/din    write request and data (ignored when full unless popping)
//   pop         read request (ignored when empty)
//   full/empty  occupancy status
//   dout        head entry
module mul_acc_fifo #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign empty   = count == 2'd0;
    assign full    = count == 2'd2;
    assign do_pop  = pop && !empty;
    // When full, the write slot equals the head slot being popped, so a
    // simultaneous push/pop overwrites the departing entry.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= !wr_ptr;
            end
            if (do_pop)
                rd_ptr <= !rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/mul_acc_stage.sv
// mul_acc_stage: sums each group of ACC_LEN multiplier products and hands the
// results out through a 2-entry buffer with a valid/ready handshake.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         mul_acc_if.slave: prod_en_in, prod_in, clr_in, acc_ready in;
//               acc_valid, acc_out, acc_last_cnt, ovf_flag out
//   ACC_LEN     products per group (1..255); ACC_W result width (>= 16)
// Build option: define MUL_ACC_SAT_EN to saturate sums at 2^ACC_W-1 instead
// of wrapping.
module mul_acc_stage
    import mul_acc_pkg::*;
#(
    parameter int ACC_LEN = 8,
    parameter int ACC_W   = 20
) (
    input logic       clk,
    input logic       rst_n,
    mul_acc_if.slave  bus
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_base;
    acc_state_e       state;
    logic             closing;
    logic             pop;
    logic             full;
    logic             empty;
    logic [ACC_W-1:0] head;
    logic             ovf;
    logic             ovf_nxt;

    assign state = (cnt == '0) ? ACC_STATE_IDLE : ACC_STATE_ACCUM;

    // A clear in the same cycle as a product makes that product the first of
    // a fresh group, so the sum and count start from zero.
    always_comb begin
        base     = (bus.clr_in || state == ACC_STATE_IDLE) ? '0 : acc;
        cnt_base = bus.clr_in ? '0 : cnt;
        closing  = bus.prod_en_in && cnt_base == CNT_W'(ACC_LEN - 1);
        acc_nxt  = acc;
        cnt_nxt  = cnt;
        if (bus.clr_in) begin
            acc_nxt = '0;
            cnt_nxt = '0;
        end
        if (bus.prod_en_in) begin
            acc_nxt = closing ? '0 : sum;
            cnt_nxt = closing ? '0 : cnt_base + CNT_W'(1);
        end
    end

`ifdef MUL_ACC_SAT_EN
    logic [63:0] sat_sum;
    assign sat_sum = sat_add(64'(base), 64'(bus.prod_in), unsigned'(ACC_W));
    assign sum     = sat_sum[ACC_W-1:0];
`else
    assign sum = base + ACC_W'(bus.prod_in);
`endif

    assign pop = !empty && bus.acc_ready;

    // A closing result is dropped only when the buffer is full and nothing
    // leaves this cycle; clear overrides a same-cycle drop.
    always_comb begin
        ovf_nxt = ovf;
        if (closing && full && !pop)
            ovf_nxt = 1'b1;
        if (bus.clr_in)
            ovf_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
        end
    end

    mul_acc_fifo #(
        .W (ACC_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (closing),
        .pop   (pop),
        .din   (sum),
        .full  (full),
        .empty (empty),
        .dout  (head)
    );

    assign bus.acc_valid    = !empty;
    assign bus.acc_out      = head;
    assign bus.acc_last_cnt = cnt;
    assign bus.ovf_flag     = ovf;

endmodule
